fb_write_arbiter: RTL and testbench

FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

---
 rtl/fb_write_arbiter.sv | 131 +++++++++++++
 tb/tb_fb_write_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fb_write_arbiter.sv
// rtl/fb_write_arbiter.sv - two-requester round-robin framebuffer write arbiter with full-frame clear sweep
// Registered write port; grants are combinational acknowledges accepted in the same cycle.
module fb_write_arbiter #(
  parameter int ADDR_WIDTH = 15,
  parameter int FB_SIZE    = 19200
) (
  input  logic                  clk_25,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic                  pix0,
  input  logic                  pix1,
  output logic                  gnt0,
  output logic                  gnt1,
  input  logic                  clear_start,
  input  logic                  clear_value,
  output logic                  clear_busy,
  output logic                  clear_done,
  output logic                  range_err,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic                  pixel
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FB_SIZE - 1);
  localparam logic [ADDR_WIDTH:0]   SIZE_EXT  = (ADDR_WIDTH + 1)'(FB_SIZE);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                  state_q, state_d;
  logic                    prio_q, prio_d;       // 1: requester 1 is favoured on a tie
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    clear_val_q, clear_val_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   write_addr_q, write_addr_d;
  logic                    pixel_q, pixel_d;
  logic                    clear_done_q, clear_done_d;
  logic                    range_err_q, range_err_d;

  logic                    sel0, sel1;
  logic [ADDR_WIDTH-1:0]   g_addr;
  logic                    g_pix;

  always_comb begin
    sel1   = req1 && (!req0 || prio_q);
    sel0   = req0 && !sel1;
    g_addr = sel1 ? addr1 : addr0;
    g_pix  = sel1 ? pix1 : pix0;

    gnt0         = 1'b0;
    gnt1         = 1'b0;
    state_d      = state_q;
    prio_d       = prio_q;
    cnt_d        = cnt_q;
    clear_val_d  = clear_val_q;
    we_d         = 1'b0;
    write_addr_d = write_addr_q;
    pixel_d      = pixel_q;
    clear_done_d = 1'b0;
    range_err_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (clear_start) begin
          state_d     = CLEAR;
          clear_val_d = clear_value;
          cnt_d       = '0;
        end else if (!reset && (sel0 || sel1)) begin
          gnt0   = sel0;
          gnt1   = sel1;
          prio_d = sel0;
          // Out-of-range writes are consumed but never reach the framebuffer.
          if ({1'b0, g_addr} >= SIZE_EXT) begin
            range_err_d = 1'b1;
          end else begin
            we_d         = 1'b1;
            write_addr_d = g_addr;
            pixel_d      = g_pix;
          end
        end
      end
      CLEAR: begin
        we_d         = 1'b1;
        write_addr_d = cnt_q;
        pixel_d      = clear_val_q;
        if (cnt_q == LAST_ADDR) begin
          state_d      = IDLE;
          cnt_d        = '0;
          clear_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_25) begin
    if (reset) begin
      state_q      <= IDLE;
      prio_q       <= 1'b0;
      cnt_q        <= '0;
      clear_val_q  <= 1'b0;
      we_q         <= 1'b0;
      write_addr_q <= '0;
      pixel_q      <= 1'b0;
      clear_done_q <= 1'b0;
      range_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      cnt_q        <= cnt_d;
      clear_val_q  <= clear_val_d;
      we_q         <= we_d;
      write_addr_q <= write_addr_d;
      pixel_q      <= pixel_d;
      clear_done_q <= clear_done_d;
      range_err_q  <= range_err_d;
    end
  end

  assign clear_busy = (state_q == CLEAR);
  assign clear_done = clear_done_q;
  assign range_err  = range_err_q;
  assign we         = we_q;
  assign write_addr = write_addr_q;
  assign pixel      = pixel_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb/tb_fb_write_arbiter.sv - directed self-checking bench for fb_write_arbiter
module tb_fb_write_arbiter;

  localparam int AW = 15;
  localparam int FS = 19200;

  logic          clk_25 = 1'b0;
  logic          reset;
  logic          req0, req1, pix0, pix1;
  logic [AW-1:0] addr0, addr1;
  logic          gnt0, gnt1;
  logic          clear_start, clear_value;
  logic          clear_busy, clear_done, range_err, we, pixel;
  logic [AW-1:0] write_addr;

  int total = 0;
  int bad   = 0;

  always #5 clk_25 = ~clk_25;

  fb_write_arbiter #(.ADDR_WIDTH(AW), .FB_SIZE(FS)) dut (
    .clk_25(clk_25), .reset(reset),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .pix0(pix0), .pix1(pix1), .gnt0(gnt0), .gnt1(gnt1),
    .clear_start(clear_start), .clear_value(clear_value),
    .clear_busy(clear_busy), .clear_done(clear_done), .range_err(range_err),
    .we(we), .write_addr(write_addr), .pixel(pixel)
  );

  task automatic tick;
    @(posedge clk_25);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int sweep_err;
    int done_cnt;
    int waited;

    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
    pix0 = 1'b0; pix1 = 1'b0; clear_start = 1'b0; clear_value = 1'b0;
    tick; tick;
    req0 = 1'b1; #1;
    chk("reset_gnt0", gnt0, 0);
    chk("reset_we", we, 0);
    chk("reset_addr", write_addr, 0);
    chk("reset_pixel", pixel, 0);
    chk("reset_busy", clear_busy, 0);
    chk("reset_done", clear_done, 0);
    chk("reset_rerr", range_err, 0);
    tick;

    // single requester 0
    reset = 1'b0; req0 = 1'b1; addr0 = 5; pix0 = 1'b1; #1;
    chk("r0_gnt0", gnt0, 1);
    chk("r0_gnt1", gnt1, 0);
    tick;
    req0 = 1'b0;
    chk("r0_we", we, 1);
    chk("r0_addr", write_addr, 5);
    chk("r0_pixel", pixel, 1);
    tick;
    chk("idle_we", we, 0);
    chk("idle_addr_hold", write_addr, 5);
    chk("idle_pixel_hold", pixel, 1);

    // single requester 1 leaves the pointer favouring requester 0
    req1 = 1'b1; addr1 = 7; pix1 = 1'b0; #1;
    chk("r1_gnt1", gnt1, 1);
    tick;
    chk("r1_addr", write_addr, 7);
    chk("r1_pixel", pixel, 0);

    // both requesting: 0,1,0,1
    req0 = 1'b1; addr0 = 10; pix0 = 1'b1;
    req1 = 1'b1; addr1 = 20; pix1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_gnt0", gnt0, (i % 2 == 0) ? 1 : 0);
      chk("rr_gnt1", gnt1, (i % 2 == 0) ? 0 : 1);
      tick;
      chk("rr_addr", write_addr, (i % 2 == 0) ? 10 : 20);
      chk("rr_we", we, 1);
    end
    req0 = 1'b0; req1 = 1'b0;

    // out-of-range address consumed, write suppressed
    req1 = 1'b1; addr1 = 15'(FS); pix1 = 1'b1; #1;
    chk("oor_gnt1", gnt1, 1);
    tick;
    req1 = 1'b0;
    chk("oor_we", we, 0);
    chk("oor_rerr", range_err, 1);
    chk("oor_addr_hold", write_addr, 20);
    tick;
    chk("oor_rerr_pulse", range_err, 0);

    // clear with a competing request
    clear_start = 1'b1; clear_value = 1'b1; req0 = 1'b1; addr0 = 33; pix0 = 1'b0; #1;
    chk("clr_start_gnt0", gnt0, 0);
    tick;
    clear_start = 1'b0; clear_value = 1'b0;
    chk("clr_busy_first", clear_busy, 1);
    chk("clr_we_first", we, 0);
    sweep_err = 0; done_cnt = 0;
    for (int k = 0; k < FS; k++) begin
      if (gnt0 !== 1'b0) sweep_err++;
      tick;
      if (we !== 1'b1 || write_addr !== AW'(k) || pixel !== 1'b1) sweep_err++;
      if (k < FS - 1 && clear_busy !== 1'b1) sweep_err++;
      if (clear_done === 1'b1) done_cnt++;
    end
    chk("clr_sweep_errs", sweep_err, 0);
    chk("clr_done_count", done_cnt, 1);
    chk("clr_last_addr", write_addr, FS - 1);
    chk("clr_done_end", clear_done, 1);
    chk("clr_busy_end", clear_busy, 0);
    chk("clr_gnt0_end", gnt0, 1);
    tick;
    req0 = 1'b0;
    chk("post_clr_addr", write_addr, 33);
    chk("post_clr_pixel", pixel, 0);
    chk("post_clr_done", clear_done, 0);

    // clear_start re-pulsed mid-sweep is ignored; value latched at start
    clear_start = 1'b1; clear_value = 1'b0;
    tick;
    clear_start = 1'b0; clear_value = 1'b1;
    sweep_err = 0; done_cnt = 0;
    for (int k = 0; k < FS + 3; k++) begin
      clear_start = (k == 50) ? 1'b1 : 1'b0;
      tick;
      if (k < FS && (we !== 1'b1 || write_addr !== AW'(k) || pixel !== 1'b0)) sweep_err++;
      if (clear_done === 1'b1) done_cnt++;
    end
    clear_start = 1'b0;
    chk("restart_sweep_errs", sweep_err, 0);
    chk("restart_done_count", done_cnt, 1);
    chk("restart_idle_busy", clear_busy, 0);

    // pointer survives a clear: last grant was requester 0
    req0 = 1'b1; req1 = 1'b1; addr0 = 1; addr1 = 2; #1;
    chk("ptr_after_clr_gnt1", gnt1, 1);
    chk("ptr_after_clr_gnt0", gnt0, 0);
    req0 = 1'b0; req1 = 1'b0;
    tick;

    // reset mid-clear
    clear_start = 1'b1; clear_value = 1'b1;
    tick;
    clear_start = 1'b0;
    waited = 0;
    while (!(we === 1'b1 && write_addr === AW'(100)) && waited < 200) begin
      tick;
      waited++;
    end
    chk("abort_reached_100", (waited < 200) ? 1 : 0, 1);
    reset = 1'b1; req0 = 1'b1; #1;
    chk("abort_gnt_in_reset", gnt0, 0);
    tick;
    chk("abort_we", we, 0);
    chk("abort_busy", clear_busy, 0);
    chk("abort_addr", write_addr, 0);
    chk("abort_done", clear_done, 0);
    reset = 1'b0; req0 = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      tick;
      if (clear_done === 1'b1 || we === 1'b1) done_cnt++;
    end
    chk("abort_quiet", done_cnt, 0);

    // pointer back to requester 0 after reset
    req0 = 1'b1; req1 = 1'b1; addr0 = 3; addr1 = 4; #1;
    chk("ptr_reset_gnt0", gnt0, 1);
    tick;
    req0 = 1'b0; req1 = 1'b0;
    chk("ptr_reset_addr", write_addr, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
